// File: rtl/hpf_select_multi.sv
// Shared Alex HPF selector: picks the band for the lowest enabled RX frequency (or TX during PTT),
// with hysteresis, a settle timer against relay chatter, a PTT fast path and a manual override.
module hpf_select_multi #(
  parameter int          NUM_CH        = 2,
  parameter int          FREQ_W        = 32,
  parameter int unsigned EDGE0         = 1800000,
  parameter int unsigned EDGE1         = 6500000,
  parameter int unsigned EDGE2         = 9500000,
  parameter int unsigned EDGE3         = 13000000,
  parameter int unsigned EDGE4         = 20000000,
  parameter int unsigned HYST          = 10000,
  parameter int unsigned SETTLE_CYCLES = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH*FREQ_W-1:0] rx_freq,
  input  logic [NUM_CH-1:0]        rx_enable,
  input  logic [FREQ_W-1:0]        tx_freq,
  input  logic                     ptt,
  input  logic                     manual_en,
  input  logic [5:0]               manual_hpf,
  output logic [5:0]               HPF,
  output logic [2:0]               band,
  output logic                     hpf_update,
  output logic                     settling
);

  localparam int FW1   = FREQ_W + 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  function automatic logic [FW1-1:0] edge_at(input logic [2:0] k);
    case (k)
      3'd0:    return FW1'(EDGE0);
      3'd1:    return FW1'(EDGE1);
      3'd2:    return FW1'(EDGE2);
      3'd3:    return FW1'(EDGE3);
      default: return FW1'(EDGE4);
    endcase
  endfunction

  function automatic logic [5:0] hpf_of(input logic [2:0] b);
    case (b)
      3'd0:    return 6'b100000;
      3'd1:    return 6'b010000;
      3'd2:    return 6'b001000;
      3'd3:    return 6'b000100;
      3'd4:    return 6'b000001;
      3'd5:    return 6'b000010;
      default: return 6'b100000;
    endcase
  endfunction

  logic [FREQ_W-1:0] f_eff_q, f_eff_d;
  logic              valid1_q, valid1_d;
  logic              ptt1_q, ptt1_d;
  logic [2:0]        cand2_q, cand2_d;
  logic              valid2_q, valid2_d;
  logic              ptt2_q, ptt2_d;
  logic              ptt2_prev_q, ptt2_prev_d;
  logic [2:0]        band_q, band_d;
  logic [5:0]        hpf_q, hpf_d;
  logic              hpf_update_q, hpf_update_d;
  logic              settling_q, settling_d;
  logic [2:0]        pending_q, pending_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              force_q, force_d;

  logic [FREQ_W-1:0] f_min;
  logic [FW1-1:0]    f_ext, lower;
  logic [2:0]        raw;
  logic              in_window;
  logic              commit;
  logic [2:0]        commit_band;

  // Stage 1: effective frequency
  always_comb begin
    f_min = '1;
    for (int n = 0; n < NUM_CH; n++) begin
      if (rx_enable[n] && (rx_freq[n*FREQ_W +: FREQ_W] < f_min)) begin
        f_min = rx_freq[n*FREQ_W +: FREQ_W];
      end
    end
    f_eff_d  = ptt ? tx_freq : f_min;
    valid1_d = ptt | (|rx_enable);
    ptt1_d   = ptt;
  end

  // Stage 2: raw band plus hysteresis around the committed band
  always_comb begin
    f_ext = {1'b0, f_eff_q};
    raw   = 3'd0;
    for (int k = 0; k < 5; k++) begin
      if (f_ext >= edge_at(3'(k))) raw = raw + 3'd1;
    end
    lower     = (band_q == 3'd0) ? '0 : edge_at(band_q - 3'd1) - FW1'(HYST);
    in_window = (f_ext >= lower) &&
                ((band_q >= 3'd5) || (f_ext < edge_at(band_q) + FW1'(HYST)));
    cand2_d   = in_window ? band_q : raw;
    valid2_d  = valid1_q;
    ptt2_d    = ptt1_q;
  end

  // Commit logic
  always_comb begin
    band_d      = band_q;
    hpf_d       = hpf_q;
    settling_d  = settling_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    force_d     = force_q;
    ptt2_prev_d = ptt2_q;
    commit      = 1'b0;
    commit_band = cand2_q;

    if (manual_en) begin
      hpf_d      = manual_hpf;
      cnt_d      = '0;
      settling_d = 1'b0;
      force_d    = 1'b1;
    end else if (!valid2_q) begin
      cnt_d = '0;
    end else if (force_q || ptt2_q || (ptt2_q != ptt2_prev_q)) begin
      commit     = 1'b1;
      force_d    = 1'b0;
      cnt_d      = '0;
      settling_d = 1'b0;
    end else if (cand2_q == band_q) begin
      cnt_d      = '0;
      settling_d = 1'b0;
    end else if ((cand2_q != pending_q) || !settling_q) begin
      cnt_d = '0;
      if (SETTLE_CYCLES == 0) begin
        commit     = 1'b1;
        settling_d = 1'b0;
      end else begin
        pending_d  = cand2_q;
        settling_d = 1'b1;
      end
    end else if (cnt_q == CNT_LAST) begin
      commit      = 1'b1;
      commit_band = pending_q;
      cnt_d       = '0;
      settling_d  = 1'b0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (commit) begin
      band_d = commit_band;
      hpf_d  = hpf_of(commit_band);
    end
    hpf_update_d = (hpf_d != hpf_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      f_eff_q      <= '0;
      valid1_q     <= 1'b0;
      ptt1_q       <= 1'b0;
      cand2_q      <= 3'd0;
      valid2_q     <= 1'b0;
      ptt2_q       <= 1'b0;
      ptt2_prev_q  <= 1'b0;
      band_q       <= 3'd0;
      hpf_q        <= 6'b100000;
      hpf_update_q <= 1'b0;
      settling_q   <= 1'b0;
      pending_q    <= 3'd0;
      cnt_q        <= '0;
      force_q      <= 1'b0;
    end else begin
      f_eff_q      <= f_eff_d;
      valid1_q     <= valid1_d;
      ptt1_q       <= ptt1_d;
      cand2_q      <= cand2_d;
      valid2_q     <= valid2_d;
      ptt2_q       <= ptt2_d;
      ptt2_prev_q  <= ptt2_prev_d;
      band_q       <= band_d;
      hpf_q        <= hpf_d;
      hpf_update_q <= hpf_update_d;
      settling_q   <= settling_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      force_q      <= force_d;
    end
  end

  assign HPF        = hpf_q;
  assign band       = band_q;
  assign hpf_update = hpf_update_q;
  assign settling   = settling_q;

endmodule

// File: doc/hpf_select_multi.md
Name: hpf_select_multi

Overview:
- Parametrised successor to the single-receiver Alex HPF band decoder.
- Selects one HPF for the shared Alex HPF bank, using the lowest frequency among enabled receivers, or the TX frequency during PTT.
- Adds hysteresis around band edges, a settle counter against relay chatter, a fast path for PTT, and a manual override.
- Drives the Alex SPI serializer: emits a one-cycle update strobe each time the committed HPF code changes.

Parameters:
NUM_CH, 2, number of receiver frequency inputs (1..8)
FREQ_W, 32, frequency width in Hz
EDGE0, 1800000, bypass / 1.5MHz boundary (Hz)
EDGE1, 6500000, 1.5MHz / 6.5MHz boundary
EDGE2, 9500000, 6.5MHz / 9.5MHz boundary
EDGE3, 13000000, 9.5MHz / 13MHz boundary
EDGE4, 20000000, 13MHz / 20MHz boundary
HYST, 10000, hysteresis half-width in Hz; must be < EDGE0 and < half the smallest edge gap
SETTLE_CYCLES, 1024, cycles a new RX candidate must hold before commit; 0 = commit next cycle

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_freq  in  NUM_CH*FREQ_W  receiver frequencies; channel n is at bits [n*FREQ_W +: FREQ_W]
rx_enable  in  NUM_CH  per-receiver enable mask
tx_freq  in  FREQ_W  transmit frequency
ptt  in  1  transmit active
manual_en  in  1  manual override enable
manual_hpf  in  6  manual HPF code, passed through unchecked
HPF  out  6  committed one-hot HPF code to the Alex serializer
band  out  3  committed band index 0..5
hpf_update  out  1  one-cycle pulse when HPF changes
settling  out  1  high while a pending candidate is counting

Behaviour:
- Band index to HPF code mapping:
  - 0 (bypass) = 100000
  - 1 (1.5MHz) = 010000
  - 2 (6.5MHz) = 001000
  - 3 (9.5MHz) = 000100
  - 4 (13MHz) = 000001
  - 5 (20MHz) = 000010
- Reset: HPF=100000, band=0, hpf_update=0, settling=0, counter=0, pipeline registers cleared (valid=0).
- Stage 1 (registered):
  - If ptt=1: f_eff=tx_freq.
  - Otherwise: f_eff = unsigned minimum of rx_freq over enabled channels; ties are irrelevant.
  - valid1=0 when ptt=0 and rx_enable=0.
  - ptt is registered alongside as ptt1.
- Stage 2 (registered):
  - raw = number of EDGEk <= f_eff. A frequency exactly on an edge selects the upper band.
  - Committed window for band c: lower = EDGE(c-1) (0 for c=0), upper = EDGE(c) (unbounded for c=5).
  - cand = band if lower-HYST <= f_eff < upper+HYST; otherwise cand = raw.
  - For c=0 the lower limit is 0; do no subtraction below 0.
  - ptt2 and valid2 are registered alongside.
- Commit logic, evaluated each cycle on stage 2 outputs:
  - manual_en=1 (checked on the live input, highest priority): HPF <= manual_hpf on the next edge. band unchanged. Counter cleared, settling=0.
  - manual_en falling: the next non-manual commit is forced, regardless of match, at the next valid2 cycle.
  - valid2=0: hold everything; counter cleared.
  - Fast path, when ptt2=1 or ptt2 differs from its previous value: commit cand on the next edge with no settle. Counter cleared.
  - Otherwise, if cand == band: cancel; counter=0, settling=0.
  - Otherwise, if cand differs from pending, or settling=0: pending<=cand, counter<=0, settling<=1. If SETTLE_CYCLES=0, commit instead.
  - Otherwise, counter increments. When counter == SETTLE_CYCLES-1, commit pending and set settling=0.
- Commit: band<=new, HPF<=map(new).
- hpf_update=1 for exactly one cycle, registered together with the HPF change, only if the 6-bit HPF value actually differs. No pulse on commits that rewrite the same code.
- Latency:
  - RX change to HPF change = 2 + SETTLE_CYCLES + 1 cycles after the input edge.
  - PTT change to HPF change = 3 cycles.
  - Manual = 1 cycle.
- Reset mid-settle aborts the pending candidate; HPF returns to bypass with no hpf_update pulse.
- Arithmetic is unsigned FREQ_W. Window compares use FREQ_W+1 bits so upper+HYST cannot wrap.

Test Plan:
- Reset, then rx_enable=01, rx_freq0=7100000, SETTLE_CYCLES=16 -> settling high 16 cycles; HPF=001000, band=2, one hpf_update pulse 19 cycles after input.
- Band 2 committed; rx_freq0 steps to 9505000 (inside HYST), then 9515000 -> no change for the first step; the second commits HPF=000100 after settle.
- rx_enable=11, rx0=14200000, rx1=3600000 -> HPF=010000 (min frequency wins). Disable rx1 -> settles to 000001.
- Candidate toggles 2->3->2 faster than SETTLE_CYCLES -> HPF never changes, no hpf_update, counter restarts each toggle.
- RX at 3.6MHz committed; ptt=1 with tx_freq=28400000 -> HPF=000010 in 3 cycles. ptt=0 -> 010000 in 3 cycles, no settle.
- manual_en=1, manual_hpf=100000 -> HPF follows in 1 cycle with pulse. Release -> forced commit of cand. Assert reset mid-settle -> HPF=100000, settling=0, no pulse.
